// File: rtl/greenhouse_actuator_driver.sv
`default_nettype none
// ============================================================================
//  Module   : greenhouse_actuator_driver
//  Function : Turns 6 actuator requests into drive signals with min on/off
//             hold times and a power budget on channels 0..4 (ch5 exempt).
//  Revision : 1.0  initial release
// ============================================================================
module greenhouse_actuator_driver #(
    parameter int MIN_ON     = 5,
    parameter int MIN_OFF    = 3,
    parameter int MAX_ACTIVE = 2,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] A_cmd,
    output logic [5:0] DRV,
    output logic [5:0] PEND,
    output logic [2:0] ACTIVE_CNT,
    output logic       SAT
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_RUN      = 2'd1;
    localparam logic [1:0]       c_COOL     = 2'd2;
    localparam logic [CNT_W-1:0] c_ON_LOAD  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] c_OFF_LOAD = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [2:0]       c_MAX_ACT  = 3'(MAX_ACTIVE);

    logic [5:0][1:0]       state_q, state_d;
    logic [5:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]            drv_q, drv_d;
    logic [5:0]            pend_q, pend_d;
    logic [2:0]            active_q, active_d;
    logic                  sat_q, sat_d;

    logic [5:0]            w_elig;
    logic [5:0]            w_grant;
    logic [2:0]            w_active;
    logic [2:0]            w_slots;
    logic [2:0]            w_slots_left;

    always_comb begin
        w_active = '0;
        for (int i = 0; i < 5; i++) begin
            if (state_q[i] == c_RUN) begin
                w_active = w_active + 3'd1;
            end
        end
        w_slots = (w_active >= c_MAX_ACT) ? 3'd0 : (c_MAX_ACT - w_active);
        for (int i = 0; i < 6; i++) begin
            w_elig[i] = (state_q[i] == c_IDLE) ||
                        ((state_q[i] == c_COOL) && (cnt_q[i] == '0));
        end
    end

    // Fixed priority, highest channel first; the vent channel bypasses the budget.
    always_comb begin
        w_grant      = '0;
        w_slots_left = w_slots;
        for (int i = 4; i >= 0; i--) begin
            if (w_elig[i] && A_cmd[i] && (w_slots_left != 3'd0)) begin
                w_grant[i]   = 1'b1;
                w_slots_left = w_slots_left - 3'd1;
            end
        end
        w_grant[5] = w_elig[5] && A_cmd[5];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 6; i++) begin
            case (state_q[i])
                c_IDLE: begin
                    if (w_grant[i]) begin
                        state_d[i] = c_RUN;
                        cnt_d[i]   = c_ON_LOAD;
                    end
                end
                c_RUN: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - c_ONE;
                    end else if (!A_cmd[i]) begin
                        state_d[i] = c_COOL;
                        cnt_d[i]   = c_OFF_LOAD;
                    end
                end
                c_COOL: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - c_ONE;
                    end else if (w_grant[i]) begin
                        state_d[i] = c_RUN;
                        cnt_d[i]   = c_ON_LOAD;
                    end else begin
                        state_d[i] = c_IDLE;
                    end
                end
                default: begin
                    state_d[i] = c_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Status is derived from the next state so it lines up with DRV.
    always_comb begin
        active_d = '0;
        for (int i = 0; i < 6; i++) begin
            drv_d[i] = (state_d[i] == c_RUN);
        end
        for (int i = 0; i < 5; i++) begin
            if (drv_d[i]) begin
                active_d = active_d + 3'd1;
            end
        end
        pend_d = A_cmd & ~drv_d;
        sat_d  = (active_d == c_MAX_ACT) && (|pend_d[4:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= '0;
            cnt_q    <= '0;
            drv_q    <= '0;
            pend_q   <= '0;
            active_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            drv_q    <= drv_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            sat_q    <= sat_d;
        end
    end

    assign DRV        = drv_q;
    assign PEND       = pend_q;
    assign ACTIVE_CNT = active_q;
    assign SAT        = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_greenhouse_actuator_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_greenhouse_actuator_driver
//  Function : Directed and random stimulus against a time-in-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_greenhouse_actuator_driver;

    localparam int MIN_ON     = 5;
    localparam int MIN_OFF    = 3;
    localparam int MAX_ACTIVE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] A_cmd;
    logic [5:0] DRV;
    logic [5:0] PEND;
    logic [2:0] ACTIVE_CNT;
    logic       SAT;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Model: each channel is just "driven or not" plus how long it has been so.
    bit         m_drv [6];
    int         m_age [6];
    logic [5:0] exp_drv;
    logic [5:0] exp_pend;
    logic [2:0] exp_cnt;
    logic       exp_sat;

    greenhouse_actuator_driver #(
        .MIN_ON    (MIN_ON),
        .MIN_OFF   (MIN_OFF),
        .MAX_ACTIVE(MAX_ACTIVE),
        .CNT_W     (8)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .A_cmd     (A_cmd),
        .DRV       (DRV),
        .PEND      (PEND),
        .ACTIVE_CNT(ACTIVE_CNT),
        .SAT       (SAT)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_update(input logic [5:0] a, input logic r);
        bit nxt [6];
        int busy;
        int slots;
        int cnt;
        if (r) begin
            for (int i = 0; i < 6; i++) begin
                m_drv[i] = 1'b0;
                m_age[i] = MIN_OFF;
            end
            exp_drv  = '0;
            exp_pend = '0;
            exp_cnt  = '0;
            exp_sat  = 1'b0;
            return;
        end
        busy = 0;
        for (int i = 0; i < 5; i++) busy += m_drv[i] ? 1 : 0;
        slots = (MAX_ACTIVE > busy) ? (MAX_ACTIVE - busy) : 0;
        for (int i = 5; i >= 0; i--) begin
            if (m_drv[i]) begin
                nxt[i] = !(m_age[i] >= MIN_ON && !a[i]);
            end else if (m_age[i] >= MIN_OFF && a[i] && (i == 5 || slots > 0)) begin
                nxt[i] = 1'b1;
                if (i != 5) slots--;
            end else begin
                nxt[i] = 1'b0;
            end
        end
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (nxt[i] != m_drv[i]) m_age[i] = 1;
            else if (m_age[i] < 1000) m_age[i]++;
            m_drv[i]   = nxt[i];
            exp_drv[i] = nxt[i];
            if (i < 5 && nxt[i]) cnt++;
        end
        exp_pend = a & ~exp_drv;
        exp_cnt  = 3'(cnt);
        exp_sat  = (cnt == MAX_ACTIVE) && (|exp_pend[4:0]);
    endtask

    task automatic step(input logic [5:0] a, input logic r);
        A_cmd = a;
        reset = r;
        @(posedge clk);
        cycle++;
        model_update(a, r);
        #1;
        check_eq("DRV",        {2'b00, DRV},        {2'b00, exp_drv});
        check_eq("PEND",       {2'b00, PEND},       {2'b00, exp_pend});
        check_eq("ACTIVE_CNT", {5'b0, ACTIVE_CNT},  {5'b0, exp_cnt});
        check_eq("SAT",        {7'b0, SAT},         {7'b0, exp_sat});
    endtask

    initial begin
        logic [5:0] a;
        A_cmd = '0;
        reset = 1'b1;
        step(6'b000000, 1'b1);
        step(6'b000000, 1'b1);
        check_eq("reset_DRV", {2'b00, DRV}, 8'h00);

        // Single request held 10 cycles, then a one-cycle request on ch0.
        for (int k = 0; k < 10; k++) step(6'b000010, 1'b0);
        for (int k = 0; k < 4; k++)  step(6'b000000, 1'b0);
        step(6'b000001, 1'b0);
        check_eq("ch0_grant", {2'b00, DRV}, 8'b0000_0001);
        for (int k = 0; k < 6; k++)  step(6'b000000, 1'b0);

        // Budget contention: ch4/ch3 win, ch2 follows once ch4 drops.
        step(6'b000000, 1'b1);
        step(6'b011110, 1'b0);
        check_eq("contend_DRV",  {2'b00, DRV},  8'b0001_1000);
        check_eq("contend_PEND", {2'b00, PEND}, 8'b0000_0110);
        check_eq("contend_SAT",  {7'b0, SAT},   8'd1);
        for (int k = 0; k < 5; k++) step(6'b001110, 1'b0);
        check_eq("ch4_release", {2'b00, DRV}, 8'b0000_1000);
        step(6'b001110, 1'b0);
        check_eq("ch2_grant", {2'b00, DRV}, 8'b0000_1100);

        // Vent bypasses the full budget.
        step(6'b101110, 1'b0);
        check_eq("vent_DRV", {2'b00, DRV}, 8'b0010_1100);
        check_eq("vent_CNT", {5'b0, ACTIVE_CNT}, 8'd2);

        // Reset mid-hold, then immediate re-grant without an off-time wait.
        step(6'b000000, 1'b1);
        step(6'b101100, 1'b0);
        step(6'b101100, 1'b0);
        step(6'b101100, 1'b1);
        check_eq("midreset_DRV", {2'b00, DRV}, 8'h00);
        step(6'b101100, 1'b0);
        check_eq("regrant_DRV", {2'b00, DRV}, 8'b0010_1100);

        // Random traffic with sticky requests and rare resets.
        a = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 7) == 0) a[b] = ~a[b];
            end
            step(a, ($urandom_range(0, 299) == 0));
            if (ACTIVE_CNT > 3'(MAX_ACTIVE)) begin
                check_eq("budget_cap", {5'b0, ACTIVE_CNT}, 8'(MAX_ACTIVE));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
